// File: rtl/execute_cycle.sv
// execute_cycle: RV32I execute stage with forwarding, ALU, branch resolution and the E/M register.
// Optional iterative multiplier (ALUControlE=1011) is built when EXECUTE_MUL_EN is defined.
module execute_cycle #(
    parameter int XLEN = 32
`ifdef EXECUTE_MUL_EN
    , parameter int MUL_CYC = 32
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            ALUSrcE_A,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            PCTargetSrcE,
    input  logic [2:0]      BranchE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);
    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, mul_res, tgt_sum;
    logic            busy, taken, eq, lt, ltu;
    logic            rw_q, rw_d, mw_q, mw_d;
    logic [1:0]      rs_q, rs_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] alu_q, alu_d, wd_q, wd_d, pc4_q, pc4_d;

    // Forwarding muxes; encoding 11 falls back to the register file value
    always_comb begin
        fwd_a = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1_E;
        fwd_b = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2_E;
        src_a = ALUSrcE_A ? PCE : fwd_a;
        src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    end

    // ALU; unused encodings produce zero
    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'b0111: alu_res = src_a << src_b[4:0];
            4'b1000: alu_res = src_a >> src_b[4:0];
            4'b1001: alu_res = $signed(src_a) >>> src_b[4:0];
            4'b1010: alu_res = src_b;
            4'b1011: alu_res = mul_res;
            default: alu_res = '0;
        endcase
    end

    // Branch resolution compares forwarded register operands only, never the immediate
    always_comb begin
        eq    = fwd_a == fwd_b;
        lt    = $signed(fwd_a) < $signed(fwd_b);
        ltu   = fwd_a < fwd_b;
        taken = 1'b0;
        case (BranchE)
            3'b001:  taken = eq;
            3'b010:  taken = !eq;
            3'b011:  taken = lt;
            3'b100:  taken = !lt;
            3'b101:  taken = ltu;
            3'b110:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        tgt_sum   = (PCTargetSrcE ? fwd_a : PCE) + Imm_Ext_E;
        PCTargetE = tgt_sum & ~{{(XLEN-1){1'b0}}, PCTargetSrcE};
        PCSrcE    = (JumpE | taken) & !busy;
        BusyE     = busy;
    end

`ifdef EXECUTE_MUL_EN
    localparam int CW = $clog2(MUL_CYC) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] ma_q, mb_q, prod_q;
    logic            is_mul;

    assign is_mul = ALUControlE == 4'b1011;

    // Multiplier FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Multiplier FSM next state: DONE always returns to IDLE so the product is written once
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = is_mul ? BUSY : IDLE;
            BUSY:    state_d = cnt_q == CW'(MUL_CYC - 1) ? DONE : BUSY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier FSM outputs: stall from issue through the last iteration
    always_comb begin
        busy    = (state_q == IDLE && is_mul) || state_q == BUSY;
        mul_res = prod_q;
    end

    // Shift-add datapath; operands are latched at issue so forwarding changes during the stall are ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            prod_q <= '0;
        end else if (state_q == IDLE && is_mul) begin
            cnt_q  <= '0;
            ma_q   <= src_a;
            mb_q   <= src_b;
            prod_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q  <= cnt_q + CW'(1);
            ma_q   <= ma_q << 1;
            mb_q   <= mb_q >> 1;
            prod_q <= mb_q[0] ? prod_q + ma_q : prod_q;
        end
    end
`else
    assign busy    = 1'b0;
    assign mul_res = '0;
`endif

    // E/M next state: a stall injects a bubble in the controls and holds the data fields
    always_comb begin
        rw_d  = RegWriteE & !busy;
        mw_d  = MemWriteE & !busy;
        rs_d  = busy ? 2'b00 : ResultSrcE;
        rd_d  = busy ? rd_q : RD_E;
        alu_d = busy ? alu_q : alu_res;
        wd_d  = busy ? wd_q : fwd_b;
        pc4_d = busy ? pc4_q : PCPlus4E;
    end

    // E/M pipeline register; reset clears everything
    always_ff @(posedge clock) begin
        if (reset) begin
            rw_q  <= 1'b0;
            mw_q  <= 1'b0;
            rs_q  <= '0;
            rd_q  <= '0;
            alu_q <= '0;
            wd_q  <= '0;
            pc4_q <= '0;
        end else begin
            rw_q  <= rw_d;
            mw_q  <= mw_d;
            rs_q  <= rs_d;
            rd_q  <= rd_d;
            alu_q <= alu_d;
            wd_q  <= wd_d;
            pc4_q <= pc4_d;
        end
    end

    assign RegWriteM  = rw_q;
    assign MemWriteM  = mw_q;
    assign ResultSrcM = rs_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_q;
    assign WriteDataM = wd_q;
    assign PCPlus4M   = pc4_q;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed-vector bench for the execute stage (multiplier checks when EXECUTE_MUL_EN is defined).
module tb_execute_cycle;
    logic        clock = 1'b0, reset;
    logic        RegWriteE, ALUSrcE, ALUSrcE_A, MemWriteE, JumpE, PCTargetSrcE;
    logic [2:0]  BranchE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    int total = 0, bad = 0;

    execute_cycle dut (
        .clock(clock), .reset(reset), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .ALUSrcE_A(ALUSrcE_A),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .PCTargetSrcE(PCTargetSrcE), .BranchE(BranchE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        RegWriteE = 0; ALUSrcE = 0; ALUSrcE_A = 0; MemWriteE = 0; JumpE = 0; PCTargetSrcE = 0;
        BranchE = 0; ResultSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
        RD_E = 0; PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1; RegWriteE = 1; MemWriteE = 1; RD1_E = 5; RD2_E = 7; RD_E = 3; PCPlus4E = 32'h44;
        step();
        total++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== 9'd0) begin
            bad++; $display("FAIL reset_ctrl got=%h want=0", {RegWriteM, MemWriteM, ResultSrcM, RD_M});
        end
        total++;
        if ({ALUResultM, WriteDataM, PCPlus4M} !== 96'd0) begin
            bad++; $display("FAIL reset_data got=%h %h %h want=0", ALUResultM, WriteDataM, PCPlus4M);
        end
        reset = 0;
        clear_inputs();
    endtask

    typedef struct packed {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] e;} alu_v_t;

    task automatic test_alu;
        alu_v_t av [0:13];
        av = '{
            '{4'h0, 32'd5,         32'd7,         32'd12},
            '{4'h1, 32'h0,         32'h1,         32'hFFFFFFFF},
            '{4'h2, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000},
            '{4'h3, 32'hF0F0F0F0,  32'h0F0F0000,  32'hFFFFF0F0},
            '{4'h4, 32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F},
            '{4'h5, 32'hFFFFFFFF,  32'h1,         32'h1},
            '{4'h5, 32'h1,         32'hFFFFFFFF,  32'h0},
            '{4'h6, 32'h1,         32'hFFFFFFFF,  32'h1},
            '{4'h7, 32'h1,         32'h24,        32'h10},
            '{4'h8, 32'h80000000,  32'd31,        32'h1},
            '{4'h9, 32'h80000000,  32'd31,        32'hFFFFFFFF},
            '{4'hA, 32'h0,         32'h12345000,  32'h12345000},
            '{4'hC, 32'h1,         32'h2,         32'h0},
            '{4'hF, 32'h1,         32'h2,         32'h0}
        };
        for (int i = 0; i < 14; i++) begin
            clear_inputs();
            ALUControlE = av[i].op; RD1_E = av[i].a; RD2_E = av[i].b;
            RegWriteE = i[0]; RD_E = 5'(i + 1);
            step();
            total++;
            if (ALUResultM !== av[i].e || RegWriteM !== i[0] || RD_M !== 5'(i + 1)) begin
                bad++;
                $display("FAIL alu[%0d] op=%h got=%h rw=%b rd=%0d want=%h rw=%b rd=%0d",
                         i, av[i].op, ALUResultM, RegWriteM, RD_M, av[i].e, i[0], i + 1);
            end
        end
        clear_inputs();
        ALUSrcE_A = 1; PCE = 32'h1000; ALUSrcE = 1; Imm_Ext_E = 32'h2000; PCPlus4E = 32'h1004; ResultSrcE = 2'b10;
        step();
        total++;
        if (ALUResultM !== 32'h3000 || PCPlus4M !== 32'h1004 || ResultSrcM !== 2'b10) begin
            bad++; $display("FAIL auipc got=%h pc4=%h rs=%b want=00003000 00001004 10", ALUResultM, PCPlus4M, ResultSrcM);
        end
        clear_inputs();
    endtask

    task automatic test_forward;
        clear_inputs();
        RD1_E = 32'h80; RD2_E = 32'h80;
        step();
        ForwardAE = 2'b10; RD1_E = 0; ALUSrcE = 1; Imm_Ext_E = 4;
        step();
        total++;
        if (ALUResultM !== 32'h104) begin
            bad++; $display("FAIL fwd_a_mem got=%h want=00000104", ALUResultM);
        end
        clear_inputs();
        ForwardBE = 2'b01; ResultW = 32'hDEADBEEF; RD2_E = 32'h0; MemWriteE = 1; ALUSrcE = 1; RD1_E = 32'h10; Imm_Ext_E = 8;
        step();
        total++;
        if (WriteDataM !== 32'hDEADBEEF || MemWriteM !== 1'b1 || ALUResultM !== 32'h18) begin
            bad++; $display("FAIL fwd_b_wb got=%h mw=%b alu=%h want=deadbeef 1 00000018", WriteDataM, MemWriteM, ALUResultM);
        end
        clear_inputs();
        ForwardBE = 2'b10; RD1_E = 32'h2; RD2_E = 32'h999;
        step();
        total++;
        if (ALUResultM !== 32'h1A) begin
            bad++; $display("FAIL fwd_b_mem got=%h want=0000001a", ALUResultM);
        end
        clear_inputs();
        ForwardAE = 2'b11; ForwardBE = 2'b11; RD1_E = 3; RD2_E = 32'h77; ResultW = 32'h55; ALUSrcE = 1; Imm_Ext_E = 1;
        step();
        total++;
        if (ALUResultM !== 32'h4 || WriteDataM !== 32'h77) begin
            bad++; $display("FAIL fwd_11 got=%h wd=%h want=00000004 00000077", ALUResultM, WriteDataM);
        end
        clear_inputs();
    endtask

    typedef struct packed {
        logic [2:0] br; logic jmp; logic tsrc; logic [31:0] a; logic [31:0] b;
        logic [31:0] pc; logic [31:0] imm; logic src; logic [31:0] tgt;
    } br_v_t;

    task automatic test_branch;
        br_v_t bv [0:9];
        bv = '{
            '{3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h40,  32'hFFFFFFF8, 1'b1, 32'h38},
            '{3'b110, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h40,  32'hFFFFFFF8, 1'b1, 32'h38},
            '{3'b100, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h40,  32'hFFFFFFF8, 1'b0, 32'h38},
            '{3'b101, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h40,  32'hFFFFFFF8, 1'b0, 32'h38},
            '{3'b001, 1'b0, 1'b0, 32'h5,        32'h5, 32'h100, 32'h10,       1'b1, 32'h110},
            '{3'b010, 1'b0, 1'b0, 32'h5,        32'h5, 32'h100, 32'h10,       1'b0, 32'h110},
            '{3'b111, 1'b0, 1'b0, 32'h5,        32'h5, 32'h100, 32'h10,       1'b0, 32'h110},
            '{3'b000, 1'b0, 1'b0, 32'h5,        32'h5, 32'h100, 32'h10,       1'b0, 32'h110},
            '{3'b000, 1'b1, 1'b0, 32'h0,        32'h0, 32'h200, 32'h20,       1'b1, 32'h220},
            '{3'b000, 1'b1, 1'b1, 32'h1001,     32'h0, 32'h40,  32'h2,        1'b1, 32'h1002}
        };
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            ALUSrcE = 1; BranchE = bv[i].br; JumpE = bv[i].jmp; PCTargetSrcE = bv[i].tsrc;
            RD1_E = bv[i].a; RD2_E = bv[i].b; PCE = bv[i].pc; Imm_Ext_E = bv[i].imm;
            #1;
            total++;
            if (PCSrcE !== bv[i].src || PCTargetE !== bv[i].tgt) begin
                bad++;
                $display("FAIL branch[%0d] got=%b %h want=%b %h", i, PCSrcE, PCTargetE, bv[i].src, bv[i].tgt);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_hold;
        clear_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b01; RD1_E = 5; RD2_E = 7; RD_E = 9; PCPlus4E = 8;
        step();
        total++;
        if (ALUResultM !== 32'd12 || RegWriteM !== 1'b1 || RD_M !== 5'd9) begin
            bad++; $display("FAIL hold_load got=%h %b %0d want=0000000c 1 9", ALUResultM, RegWriteM, RD_M);
        end
        reset = 1;
        step();
        total++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M} !== 105'd0) begin
            bad++; $display("FAIL hold_reset1 got=%h want=0", {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M});
        end
        RD1_E = 32'hAAAA; RD2_E = 32'h5555; RD_E = 31; PCPlus4E = 32'h100; ResultSrcE = 2'b11;
        step();
        total++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M} !== 105'd0) begin
            bad++; $display("FAIL hold_reset2 got=%h want=0", {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M});
        end
        reset = 0;
        clear_inputs();
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic test_mul;
        int n;
        logic rw_seen;
        clear_inputs();
        ALUControlE = 4'hB; RD1_E = 32'hFFFF; RD2_E = 32'h10001; RegWriteE = 1; RD_E = 4; JumpE = 1;
        #1;
        total++;
        if (BusyE !== 1'b1 || PCSrcE !== 1'b0) begin
            bad++; $display("FAIL mul_issue busy=%b pcsrc=%b want=1 0", BusyE, PCSrcE);
        end
        JumpE = 0;
        n = 0; rw_seen = 0;
        while (BusyE === 1'b1 && n < 40) begin
            step();
            n++;
            if (n == 1) begin RD1_E = 0; RD2_E = 0; end
            if (RegWriteM !== 1'b0) rw_seen = 1;
        end
        total++;
        if (n !== 33) begin
            bad++; $display("FAIL mul_busy_len got=%0d want=33", n);
        end
        total++;
        if (rw_seen !== 1'b0) begin
            bad++; $display("FAIL mul_bubble got=%b want=0", rw_seen);
        end
        step();
        total++;
        if (ALUResultM !== 32'hFFFFFFFF || RegWriteM !== 1'b1 || RD_M !== 5'd4) begin
            bad++; $display("FAIL mul_result got=%h %b %0d want=ffffffff 1 4", ALUResultM, RegWriteM, RD_M);
        end
        clear_inputs();
        ALUControlE = 4'hB; RD1_E = 7; RD2_E = 9;
        for (int i = 0; i < 11; i++) step();
        reset = 1; ALUControlE = 4'h0; RD1_E = 2; RD2_E = 3; RegWriteE = 1;
        step();
        reset = 0;
        total++;
        if (BusyE !== 1'b0 || RegWriteM !== 1'b0) begin
            bad++; $display("FAIL mul_reset busy=%b rw=%b want=0 0", BusyE, RegWriteM);
        end
        step();
        total++;
        if (ALUResultM !== 32'd5 || RegWriteM !== 1'b1) begin
            bad++; $display("FAIL mul_after_reset got=%h %b want=00000005 1", ALUResultM, RegWriteM);
        end
        ALUControlE = 4'hB; RD1_E = 3; RD2_E = 5;
        #1;
        n = 0;
        while (BusyE === 1'b1 && n < 40) begin
            step();
            n++;
        end
        step();
        total++;
        if (n !== 33 || ALUResultM !== 32'd15) begin
            bad++; $display("FAIL mul_rerun len=%0d got=%h want=33 0000000f", n, ALUResultM);
        end
        clear_inputs();
    endtask
`else
    task automatic test_mul;
        clear_inputs();
        ALUControlE = 4'hB; RD1_E = 3; RD2_E = 5; RegWriteE = 1;
        #1;
        total++;
        if (BusyE !== 1'b0) begin
            bad++; $display("FAIL nomul_busy got=%b want=0", BusyE);
        end
        step();
        total++;
        if (ALUResultM !== 32'h0 || RegWriteM !== 1'b1) begin
            bad++; $display("FAIL nomul_result got=%h %b want=00000000 1", ALUResultM, RegWriteM);
        end
        clear_inputs();
    endtask
`endif

    task automatic test_back_to_back;
        clear_inputs();
        RD1_E = 10; RD2_E = 3; ALUControlE = 4'h1;
        step();
        ALUControlE = 4'h0; ForwardAE = 2'b10; RD1_E = 0; RD2_E = 32'h20;
        step();
        total++;
        if (ALUResultM !== 32'h27) begin
            bad++; $display("FAIL b2b got=%h want=00000027", ALUResultM);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forward();
        test_branch();
        test_reset_hold();
        test_mul();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
